// File: rtl/ifid_fetch_stage_if.sv
// Bus bundle between the fetch stage and its environment (control, imem, ID stage).
// slave = the fetch stage itself, master = whoever drives control and instruction data.
interface ifid_fetch_stage_if;
    logic        start_i;
    logic        hazard_stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic [15:0] stall_cnt_o;

    modport slave (
        input  start_i, hazard_stall_i, flush_i, branch_target_i, instr_i,
        output pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, stall_cnt_o
    );

    modport master (
        output start_i, hazard_stall_i, flush_i, branch_target_i, instr_i,
        input  pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, stall_cnt_o
    );
endinterface

// File: rtl/ifid_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, flush/stall handling.
// Optional stall-cycle counter enabled by defining STALL_COUNTER_EN.
module ifid_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ifid_fetch_stage_if.slave     bus
);

    typedef enum logic {IDLE, RUN} stateType;

    stateType    stateReg, stateNext;
    logic [31:0] pcReg, pcNext;
    logic [31:0] ifidPcReg, ifidPcNext;
    logic [31:0] ifidInstrReg, ifidInstrNext;
    logic        ifidValidReg, ifidValidNext;
    logic        stallTaken;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stateReg     <= IDLE;
            pcReg        <= RESET_PC;
            ifidPcReg    <= 32'h0000_0000;
            ifidInstrReg <= NOP_INSTR;
            ifidValidReg <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            pcReg        <= pcNext;
            ifidPcReg    <= ifidPcNext;
            ifidInstrReg <= ifidInstrNext;
            ifidValidReg <= ifidValidNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        pcNext        = pcReg;
        ifidPcNext    = ifidPcReg;
        ifidInstrNext = ifidInstrReg;
        ifidValidNext = ifidValidReg;
        stallTaken    = 1'b0;
        case (stateReg)
            IDLE: begin
                // The start edge is itself the first fetch; stall/flush are meaningless before it.
                if (bus.start_i) begin
                    stateNext     = RUN;
                    pcNext        = pcReg + 32'd4;
                    ifidPcNext    = pcReg + 32'd4;
                    ifidInstrNext = bus.instr_i;
                    ifidValidNext = 1'b1;
                end
            end
            RUN: begin
                if (bus.flush_i) begin
                    pcNext        = {bus.branch_target_i[31:2], 2'b00};
                    ifidPcNext    = 32'h0000_0000;
                    ifidInstrNext = NOP_INSTR;
                    ifidValidNext = 1'b0;
                end else if (bus.hazard_stall_i) begin
                    stallTaken = 1'b1;
                end else begin
                    pcNext        = pcReg + 32'd4;
                    ifidPcNext    = pcReg + 32'd4;
                    ifidInstrNext = bus.instr_i;
                    ifidValidNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef STALL_COUNTER_EN
    logic [15:0] stallCntReg, stallCntNext;

    always_comb begin
        stallCntNext = stallCntReg;
        if (stallTaken && stallCntReg != 16'hFFFF)
            stallCntNext = stallCntReg + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stallCntReg <= 16'h0000;
        else
            stallCntReg <= stallCntNext;
    end

    assign bus.stall_cnt_o = stallCntReg;
`else
    logic unusedStall;
    assign unusedStall     = stallTaken;
    assign bus.stall_cnt_o = 16'h0000;
`endif

    assign bus.pc_o         = pcReg;
    assign bus.ifid_pc_o    = ifidPcReg;
    assign bus.ifid_instr_o = ifidInstrReg;
    assign bus.ifid_valid_o = ifidValidReg;

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Directed self-checking bench for ifid_fetch_stage; honours STALL_COUNTER_EN for counter expectations.
module tb_ifid_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef STALL_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rstN;
    int   errors;
    int   checks;

    ifid_fetch_stage_if bus();

    ifid_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk_i (clk),
        .rst_i (rstN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: data depends on the current fetch address.
    assign bus.instr_i = 32'h1111_0000 + bus.pc_o;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.start_i = 0; bus.hazard_stall_i = 0; bus.flush_i = 0; bus.branch_target_i = 0;
        @(negedge clk); rstN = 1'b0;
        @(negedge clk); rstN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.pc_o !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc_o, RST_PC); end
        checks++; if (bus.ifid_pc_o !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h expected %h", bus.ifid_pc_o, 32'h0); end
        checks++; if (bus.ifid_instr_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.ifid_instr_o, NOP); end
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ifid_valid_o); end
        checks++; if (bus.stall_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", bus.stall_cnt_o); end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_advance();
        logic [31:0] expPc, expInstr;
        do_reset();
        bus.start_i = 1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            expPc    = 32'(4 * e);
            expInstr = 32'h1111_0000 + 32'(4 * (e - 1));
            checks++; if (bus.pc_o !== expPc) begin errors++; $display("FAIL adv_pc e%0d: got %h expected %h", e, bus.pc_o, expPc); end
            checks++; if (bus.ifid_pc_o !== expPc) begin errors++; $display("FAIL adv_ifid_pc e%0d: got %h expected %h", e, bus.ifid_pc_o, expPc); end
            checks++; if (bus.ifid_instr_o !== expInstr) begin errors++; $display("FAIL adv_instr e%0d: got %h expected %h", e, bus.ifid_instr_o, expInstr); end
            checks++; if (bus.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL adv_valid e%0d: got %b expected 1", e, bus.ifid_valid_o); end
            $display("advance edge %0d: pc=%h ifid_pc=%h instr=%h valid=%b", e, bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_valid_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.start_i = 1;
        tick(); tick();
        bus.hazard_stall_i = 1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++; if (bus.pc_o !== 32'h8) begin errors++; $display("FAIL stall_pc e%0d: got %h expected %h", e, bus.pc_o, 32'h8); end
            checks++; if (bus.ifid_pc_o !== 32'h8) begin errors++; $display("FAIL stall_ifid_pc e%0d: got %h expected %h", e, bus.ifid_pc_o, 32'h8); end
            checks++; if (bus.ifid_instr_o !== 32'h1111_0004) begin errors++; $display("FAIL stall_instr e%0d: got %h expected %h", e, bus.ifid_instr_o, 32'h1111_0004); end
            checks++; if (bus.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid e%0d: got %b expected 1", e, bus.ifid_valid_o); end
            $display("stall edge %0d: pc=%h cnt=%h", e, bus.pc_o, bus.stall_cnt_o);
        end
        checks++; if (bus.stall_cnt_o !== (CNT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL stall_cnt: got %h expected %h", bus.stall_cnt_o, CNT_EN ? 16'd2 : 16'd0); end
    endtask

    // Runs straight after test_stall, so the counter should still read 2 (or 0).
    task automatic test_flush_priority();
        bus.flush_i = 1; bus.hazard_stall_i = 1; bus.branch_target_i = 32'h0000_0103;
        tick();
        checks++; if (bus.pc_o !== 32'h100) begin errors++; $display("FAIL flush_pc: got %h expected %h", bus.pc_o, 32'h100); end
        checks++; if (bus.ifid_instr_o !== NOP) begin errors++; $display("FAIL flush_instr: got %h expected %h", bus.ifid_instr_o, NOP); end
        checks++; if (bus.ifid_pc_o !== 32'h0) begin errors++; $display("FAIL flush_ifid_pc: got %h expected %h", bus.ifid_pc_o, 32'h0); end
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.ifid_valid_o); end
        checks++; if (bus.stall_cnt_o !== (CNT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL flush_cnt: got %h expected %h", bus.stall_cnt_o, CNT_EN ? 16'd2 : 16'd0); end
        $display("flush: pc=%h instr=%h valid=%b cnt=%h", bus.pc_o, bus.ifid_instr_o, bus.ifid_valid_o, bus.stall_cnt_o);
        bus.flush_i = 0; bus.hazard_stall_i = 0;
        tick();
        checks++; if (bus.pc_o !== 32'h104) begin errors++; $display("FAIL post_flush_pc: got %h expected %h", bus.pc_o, 32'h104); end
        checks++; if (bus.ifid_instr_o !== 32'h1111_0100) begin errors++; $display("FAIL post_flush_instr: got %h expected %h", bus.ifid_instr_o, 32'h1111_0100); end
        checks++; if (bus.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL post_flush_valid: got %b expected 1", bus.ifid_valid_o); end
        $display("post-flush advance: pc=%h ifid_pc=%h instr=%h", bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o);
    endtask

    task automatic test_wrap();
        bus.flush_i = 1; bus.branch_target_i = 32'hFFFF_FFFC;
        tick();
        checks++; if (bus.pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect_pc: got %h expected %h", bus.pc_o, 32'hFFFF_FFFC); end
        bus.flush_i = 0;
        tick();
        checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", bus.pc_o, 32'h0); end
        checks++; if (bus.ifid_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_ifid_pc: got %h expected %h", bus.ifid_pc_o, 32'h0); end
        checks++; if (bus.ifid_instr_o !== 32'h1110_FFFC) begin errors++; $display("FAIL wrap_instr: got %h expected %h", bus.ifid_instr_o, 32'h1110_FFFC); end
        checks++; if (bus.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", bus.ifid_valid_o); end
        $display("wrap: pc=%h ifid_pc=%h valid=%b", bus.pc_o, bus.ifid_pc_o, bus.ifid_valid_o);
    endtask

    task automatic test_idle_ignore();
        do_reset();
        bus.flush_i = 1; bus.hazard_stall_i = 1; bus.branch_target_i = 32'h0000_0200;
        tick(); tick();
        checks++; if (bus.pc_o !== RST_PC) begin errors++; $display("FAIL idle_pc: got %h expected %h", bus.pc_o, RST_PC); end
        checks++; if (bus.ifid_instr_o !== NOP) begin errors++; $display("FAIL idle_instr: got %h expected %h", bus.ifid_instr_o, NOP); end
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", bus.ifid_valid_o); end
        checks++; if (bus.stall_cnt_o !== 16'h0) begin errors++; $display("FAIL idle_cnt: got %h expected 0000", bus.stall_cnt_o); end
        $display("idle with flush/stall: pc=%h valid=%b", bus.pc_o, bus.ifid_valid_o);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        bus.start_i = 1;
        tick(); tick();
        bus.hazard_stall_i = 1;
        tick();
        #2 rstN = 1'b0;
        #1;
        checks++; if (bus.pc_o !== RST_PC) begin errors++; $display("FAIL async_pc: got %h expected %h", bus.pc_o, RST_PC); end
        checks++; if (bus.ifid_pc_o !== 32'h0) begin errors++; $display("FAIL async_ifid_pc: got %h expected %h", bus.ifid_pc_o, 32'h0); end
        checks++; if (bus.ifid_instr_o !== NOP) begin errors++; $display("FAIL async_instr: got %h expected %h", bus.ifid_instr_o, NOP); end
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", bus.ifid_valid_o); end
        checks++; if (bus.stall_cnt_o !== 16'h0) begin errors++; $display("FAIL async_cnt: got %h expected 0000", bus.stall_cnt_o); end
        bus.start_i = 0; bus.hazard_stall_i = 0;
        @(negedge clk); rstN = 1'b1;
        repeat (5) tick();
        checks++; if (bus.pc_o !== RST_PC) begin errors++; $display("FAIL no_start_pc: got %h expected %h", bus.pc_o, RST_PC); end
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL no_start_valid: got %b expected 0", bus.ifid_valid_o); end
        bus.start_i = 1;
        tick();
        checks++; if (bus.pc_o !== RST_PC + 32'd4) begin errors++; $display("FAIL resume_pc: got %h expected %h", bus.pc_o, RST_PC + 32'd4); end
        checks++; if (bus.ifid_instr_o !== 32'h1111_0000 + RST_PC) begin errors++; $display("FAIL resume_instr: got %h expected %h", bus.ifid_instr_o, 32'h1111_0000 + RST_PC); end
        $display("reset mid-stall then resume: pc=%h instr=%h", bus.pc_o, bus.ifid_instr_o);
    endtask

    task automatic test_stall_saturate();
        do_reset();
        bus.start_i = 1;
        tick();
        bus.hazard_stall_i = 1;
        repeat (65534) tick();
        checks++; if (bus.stall_cnt_o !== (CNT_EN ? 16'hFFFE : 16'h0)) begin errors++; $display("FAIL sat_near: got %h expected %h", bus.stall_cnt_o, CNT_EN ? 16'hFFFE : 16'h0); end
        repeat (6) tick();
        checks++; if (bus.stall_cnt_o !== (CNT_EN ? 16'hFFFF : 16'h0)) begin errors++; $display("FAIL sat_cnt: got %h expected %h", bus.stall_cnt_o, CNT_EN ? 16'hFFFF : 16'h0); end
        checks++; if (bus.pc_o !== 32'h4) begin errors++; $display("FAIL sat_pc: got %h expected %h", bus.pc_o, 32'h4); end
        bus.flush_i = 1; bus.branch_target_i = 32'h0000_0100;
        tick();
        checks++; if (bus.stall_cnt_o !== (CNT_EN ? 16'hFFFF : 16'h0)) begin errors++; $display("FAIL sat_flush_cnt: got %h expected %h", bus.stall_cnt_o, CNT_EN ? 16'hFFFF : 16'h0); end
        checks++; if (bus.pc_o !== 32'h100) begin errors++; $display("FAIL sat_flush_pc: got %h expected %h", bus.pc_o, 32'h100); end
        $display("saturation: cnt=%h pc=%h", bus.stall_cnt_o, bus.pc_o);
        bus.flush_i = 0; bus.hazard_stall_i = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstN = 1'b1;
        bus.start_i = 0; bus.hazard_stall_i = 0; bus.flush_i = 0; bus.branch_target_i = 0;
        test_reset();
        test_advance();
        test_stall();
        test_flush_priority();
        test_wrap();
        test_idle_ignore();
        test_reset_mid_stall();
        test_stall_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
